// File: rtl/nn_pkg.sv
// ---------------------------------------------------------------------------
// nn_pkg: definitions shared by the conv, pooling and linear stages.
//   NN_DATA_W   : default bits per channel value
//   NN_CHANNELS : default channels carried in parallel per beat
//   clog2()     : counter width helper
//   ch_lsb()    : channel packing; channel c lives at [c*w +: w]
// ---------------------------------------------------------------------------
package nn_pkg;

    localparam int unsigned NN_DATA_W   = 8;
    localparam int unsigned NN_CHANNELS = 2;

    // Bits needed to count 0..v-1 (v >= 2 gives the usual ceil(log2)).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Low bit of channel c in a packed multi-channel bus.
    function automatic int unsigned ch_lsb(input int unsigned c, input int unsigned w);
        return c * w;
    endfunction

endpackage

// File: rtl/maxpool_cmp.sv
// ---------------------------------------------------------------------------
// maxpool_cmp: single-channel combinational max.
//   a_i, b_i : DATA_W operands
//   max_o    : the larger operand (equal operands give that value)
// Macro MAXPOOL_SIGNED_EN selects a two's-complement compare; otherwise
// operands are compared unsigned.
// ---------------------------------------------------------------------------
module maxpool_cmp #(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] max_o
);

`ifdef MAXPOOL_SIGNED_EN
    assign max_o = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;
`else
    assign max_o = (a_i > b_i) ? a_i : b_i;
`endif

endmodule

// File: rtl/maxpool2d_stream.sv
// ---------------------------------------------------------------------------
// maxpool2d_stream: streaming 2x2 / stride-2 max-pool over a raster-ordered
// multi-channel feature map, using a half-width line buffer.
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   clear      : synchronous frame resync (zeroes col/row/hold, drops beat)
//   in_data    : one pixel, channel c at [c*DATA_W +: DATA_W]
//   in_valid   : one beat = one input pixel, no backpressure
//   out_data   : pooled pixel, same packing
//   out_valid  : one-cycle pulse, 1 clock after the window-completing beat
//   frame_done : one-cycle pulse, 1 clock after pixel (IN_H-1, IN_W-1)
// Macro MAXPOOL_SIGNED_EN (in maxpool_cmp) selects signed channel compare.
// ---------------------------------------------------------------------------
module maxpool2d_stream
    import nn_pkg::*;
#(
    parameter int unsigned DATA_W   = NN_DATA_W,
    parameter int unsigned CHANNELS = NN_CHANNELS,
    parameter int unsigned IN_W     = 6,
    parameter int unsigned IN_H     = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    input  logic                         in_valid,
    output logic [CHANNELS*DATA_W-1:0]   out_data,
    output logic                         out_valid,
    output logic                         frame_done
);

    localparam int unsigned BUS_W     = CHANNELS * DATA_W;
    localparam int unsigned LB_DEPTH  = (IN_W + 1) / 2;
    localparam int unsigned COL_W     = clog2(IN_W);
    localparam int unsigned ROW_W     = clog2(IN_H);
    localparam int unsigned LB_AW     = (LB_DEPTH > 1) ? clog2(LB_DEPTH) : 1;
    // Columns that belong to a complete window (floor semantics).
    localparam int unsigned POOL_COLS = 2 * (IN_W / 2);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [BUS_W-1:0] hold_q, hold_d;
    logic [BUS_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_done_q, frame_done_d;

    // Not reset: each entry is written on an even row before the odd row
    // reads it.
    logic [BUS_W-1:0] linebuf [LB_DEPTH];
    logic [LB_AW-1:0] lb_idx;
    logic [BUS_W-1:0] lb_rd;
    logic             lb_we;

    logic [BUS_W-1:0] max_lb;    // max(linebuf entry, pixel)
    logic [BUS_W-1:0] max_hold;  // max(hold, pixel)

    logic col_end, row_end, in_pool_col;

    assign lb_idx = LB_AW'(col_q >> 1);
    assign lb_rd  = linebuf[lb_idx];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        maxpool_cmp #(.DATA_W(DATA_W)) u_cmp_lb (
            .a_i   (lb_rd  [ch_lsb(c, DATA_W) +: DATA_W]),
            .b_i   (in_data[ch_lsb(c, DATA_W) +: DATA_W]),
            .max_o (max_lb [ch_lsb(c, DATA_W) +: DATA_W])
        );
        maxpool_cmp #(.DATA_W(DATA_W)) u_cmp_hold (
            .a_i   (hold_q  [ch_lsb(c, DATA_W) +: DATA_W]),
            .b_i   (in_data [ch_lsb(c, DATA_W) +: DATA_W]),
            .max_o (max_hold[ch_lsb(c, DATA_W) +: DATA_W])
        );
    end

    assign col_end     = (col_q == COL_W'(IN_W - 1));
    assign row_end     = (row_q == ROW_W'(IN_H - 1));
    assign in_pool_col = (32'(col_q) < POOL_COLS);

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;

        if (clear) begin
            col_d  = '0;
            row_d  = '0;
            hold_d = '0;
        end else if (in_valid) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
            frame_done_d = col_end && row_end;

            // A trailing odd column is consumed without touching window state.
            if (in_pool_col) begin
                case ({row_q[0], col_q[0]})
                    2'b00: hold_d = in_data;
                    2'b01: lb_we  = 1'b1;
                    2'b10: hold_d = max_lb;
                    2'b11: begin
                        out_data_d  = max_hold;
                        out_valid_d = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf[lb_idx] <= max_hold;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool2d_stream.sv
module tb_maxpool2d_stream;

    logic        clk = 1'b0;
    logic        reset, clear;
    logic [15:0] in_data, in_data5;
    logic        in_valid, in_valid5;
    logic [15:0] out_data, out_data5;
    logic        out_valid, out_valid5;
    logic        frame_done, frame_done5;

    always #5 clk = ~clk;

    maxpool2d_stream #(.DATA_W(8), .CHANNELS(2), .IN_W(6), .IN_H(6)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .frame_done(frame_done)
    );

    maxpool2d_stream #(.DATA_W(8), .CHANNELS(2), .IN_W(5), .IN_H(5)) dut5 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_data(in_data5), .in_valid(in_valid5),
        .out_data(out_data5), .out_valid(out_valid5), .frame_done(frame_done5)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] pix [2][64];
    int          midx [2];
    logic [15:0] got [$];
    logic [7:0]  s1_ch0 [9] = '{8'd7, 8'd9, 8'd11, 8'd19, 8'd21, 8'd23, 8'd31, 8'd33, 8'd35};
    logic [7:0]  s3_ch0 [4] = '{8'd6, 8'd8, 8'd16, 8'd18};
    logic [15:0] sgn_obs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mx(input logic [7:0] a, input logic [7:0] b);
`ifdef MAXPOOL_SIGNED_EN
        return ($signed(a) > $signed(b)) ? a : b;
`else
        return (a > b) ? a : b;
`endif
    endfunction

    // Expected pooled pixel for the window whose bottom-right pixel is (r,c).
    function automatic logic [15:0] pool(input int sel, input int r, input int c);
        int          w;
        logic [15:0] p0, p1, p2, p3;
        logic [15:0] res;
        w  = (sel != 0) ? 5 : 6;
        p0 = pix[sel][(r-1)*w + c-1];
        p1 = pix[sel][(r-1)*w + c];
        p2 = pix[sel][r*w + c-1];
        p3 = pix[sel][r*w + c];
        for (int ch = 0; ch < 2; ch++) begin
            res[ch*8 +: 8] = mx(mx(p0[ch*8 +: 8], p1[ch*8 +: 8]), mx(p2[ch*8 +: 8], p3[ch*8 +: 8]));
        end
        return res;
    endfunction

    task automatic beat(input int sel, input logic [15:0] d);
        int          w, n, r, c;
        logic        ev, efd, ov, ofd;
        logic [15:0] od;
        w = (sel != 0) ? 5 : 6;
        n = w * w;
        @(negedge clk);
        if (sel == 0) begin in_data = d; in_valid = 1'b1; end
        else          begin in_data5 = d; in_valid5 = 1'b1; end
        @(posedge clk);
        #1;
        r = midx[sel] / w;
        c = midx[sel] % w;
        pix[sel][midx[sel]] = d;
        ev  = (r % 2 == 1) && (c % 2 == 1);
        efd = (midx[sel] == n - 1);
        ov  = (sel != 0) ? out_valid5  : out_valid;
        ofd = (sel != 0) ? frame_done5 : frame_done;
        od  = (sel != 0) ? out_data5   : out_data;
        chk("out_valid", 32'(ov), 32'(ev));
        if (ev) begin
            chk("out_data", 32'(od), 32'(pool(sel, r, c)));
            got.push_back(od);
            if (sel == 0 && midx[0] == 7) sgn_obs = od;
        end
        chk("frame_done", 32'(ofd), 32'(efd));
        midx[sel] = (midx[sel] + 1) % n;
        in_valid  = 1'b0;
        in_valid5 = 1'b0;
    endtask

    task automatic idle(input int sel);
        @(negedge clk);
        in_valid  = 1'b0;
        in_valid5 = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_out_valid",  32'((sel != 0) ? out_valid5 : out_valid), 32'd0);
        chk("idle_frame_done", 32'((sel != 0) ? frame_done5 : frame_done), 32'd0);
    endtask

    // mode 0: ramp, 1: random, 2: signed-compare window at top-left
    // gaps 0: back to back, 1: idle after every beat, 2: random idles
    task automatic run(input int sel, input int mode, input int gaps, input int first, input int count);
        logic [15:0] d;
        int          last;
        last = (sel != 0) ? 24 : 35;
        for (int i = first; i < first + count; i++) begin
            d = 16'($urandom);
            if (mode == 0) begin
                d[7:0] = 8'(i);
                if (sel == 0) d[15:8] = 8'(last - i);
            end else if (mode == 2) begin
                if (i == 0) d[7:0] = 8'h80;
                if (i == 1) d[7:0] = 8'h7F;
                if (i == 6) d[7:0] = 8'h01;
                if (i == 7) d[7:0] = 8'h00;
            end
            beat(sel, d);
            if (gaps == 1 || (gaps == 2 && $urandom_range(0, 2) == 0)) idle(sel);
        end
    endtask

    task automatic check_ramp6(input string tag);
        chk({tag, "_count"}, 32'(got.size()), 32'd9);
        for (int i = 0; i < 9 && i < got.size(); i++) begin
            chk({tag, "_ch0"}, 32'(got[i][7:0]), 32'(s1_ch0[i]));
        end
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0;
        in_valid = 1'b0; in_valid5 = 1'b0;
        in_data = '0; in_data5 = '0;
        midx[0] = 0; midx[1] = 0;
        sgn_obs = '0;
        #12;
        chk("rst_out_data",    32'(out_data),    32'd0);
        chk("rst_out_valid",   32'(out_valid),   32'd0);
        chk("rst_frame_done",  32'(frame_done),  32'd0);
        chk("rst_out_data5",   32'(out_data5),   32'd0);
        chk("rst_out_valid5",  32'(out_valid5),  32'd0);
        @(negedge clk);
        reset = 1'b0;

        // back-to-back ramp frame
        got.delete();
        run(0, 0, 0, 0, 36);
        idle(0);
        check_ramp6("s1");

        // same frame with in_valid low every other cycle
        got.delete();
        run(0, 0, 1, 0, 36);
        check_ramp6("s2");

        // 5x5 map: trailing column/row never contribute
        got.delete();
        run(1, 0, 0, 0, 25);
        idle(1);
        chk("s3_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            chk("s3_ch0", 32'(got[i][7:0]), 32'(s3_ch0[i]));
        end

        // clear alongside beat 10: beat dropped, no pulse, out_data kept
        run(0, 0, 0, 0, 10);
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF;
        @(posedge clk);
        #1;
        chk("clr_out_valid",  32'(out_valid),  32'd0);
        chk("clr_frame_done", 32'(frame_done), 32'd0);
        chk("clr_out_data",   32'(out_data),   32'(pool(0, 1, 3)));
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        midx[0] = 0; midx[1] = 0;
        got.delete();
        run(0, 0, 0, 0, 36);
        check_ramp6("s4");

        // asynchronous reset between edges, right after a window completes
        run(0, 0, 0, 0, 8);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_data",  32'(out_data),  32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        midx[0] = 0; midx[1] = 0;
        got.delete();
        run(0, 0, 0, 0, 36);
        check_ramp6("s5");

        // compare sign: {80, 7F, 01, 00} on ch0
        run(0, 2, 0, 0, 8);
`ifdef MAXPOOL_SIGNED_EN
        chk("sign_window", 32'(sgn_obs[7:0]), 32'h7F);
`else
        chk("sign_window", 32'(sgn_obs[7:0]), 32'h80);
`endif
        run(0, 2, 0, 8, 28);

        // random frames with random idle cycles
        repeat (3) run(0, 1, 2, 0, 36);
        repeat (3) run(1, 1, 2, 0, 25);
        idle(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
